hazard_unit: RTL and testbench

//  Pipeline sequencer for the 5-stage CPU. Owns every stage-register enable/flush and the PC enable.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/sat_counter.sv | 16 +
 rtl/hazard_unit.sv | 112 +++++++++++
 tb/tb_hazard_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word and the hazard sequencer state.
package cpu_types_pkg;
   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {RUN, DRAIN, FLUSH, HALTED} hzd_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         en,
   output logic [W-1:0] cnt
);
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         cnt <= '0;
      else if (en && (cnt != {W{1'b1}}))
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencer: stage enables/flushes, PC enable, stall counting and the halt sequence.
module hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dren,
   input  logic             mem_dwen,
   input  logic             ex_dren,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_branch,
   input  logic             ex_beq,
   input  logic             ex_equal,
   input  logic             id_jump,
   input  logic             wb_halt,
   input  logic             flush_done,
   output logic             pcen,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             dcache_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt
);
   hzd_state_t state, next_state;
   logic       advance, taken, lu, cnt_en;
   regbits_t   lu_rt;

   assign lu_rt   = ex_rt;
   assign advance = ihit & (~(mem_dren | mem_dwen) | dhit);
   assign taken   = ex_branch & (ex_beq ~^ ex_equal);
   assign lu      = ex_dren & (lu_rt != '0) & ((lu_rt == id_rs) | (lu_rt == id_rt));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state <= RUN;
      else
         state <= next_state;
   end

   // halt is set on the FLUSH->HALTED edge and only cleared by reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         halt <= 1'b0;
      else if ((state == FLUSH) && flush_done)
         halt <= 1'b1;
   end

   // dcache_flush/flush_done handshake: dcache_flush is held high for every FLUSH
   // cycle; the first cycle flush_done is seen high completes the transfer.
   always_comb begin
      next_state   = state;
      pcen         = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      dcache_flush = 1'b0;
      cnt_en       = 1'b0;
      case (state)
         RUN: begin
            if (!advance) begin
               cnt_en = 1'b1;
            end else begin
               pcen     = 1'b1;
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
               if (taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (lu) begin
                  pcen       = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end else if (id_jump) begin
                  ifid_flush = 1'b1;
               end
               if (wb_halt)
                  next_state = DRAIN;
            end
         end
         DRAIN:  next_state = FLUSH;
         FLUSH: begin
            dcache_flush = 1'b1;
            if (flush_done)
               next_state = HALTED;
         end
         HALTED: next_state = HALTED;
         default: next_state = RUN;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK (CLK),
      .nRST(nRST),
      .en  (cnt_en),
      .cnt (stall_cnt)
   );
endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit with a queue-based scoreboard.
module tb_hazard_unit;
   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit, dhit, mem_dren, mem_dwen, ex_dren;
   logic [4:0]  ex_rt, id_rs, id_rt;
   logic        ex_branch, ex_beq, ex_equal, id_jump, wb_halt, flush_done;
   logic        pcen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
   logic        dcache_flush, halt;
   logic [31:0] stall_cnt;

   hazard_unit #(.CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen), .ex_dren(ex_dren),
      .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .ex_branch(ex_branch), .ex_beq(ex_beq), .ex_equal(ex_equal),
      .id_jump(id_jump), .wb_halt(wb_halt), .flush_done(flush_done),
      .pcen(pcen), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .dcache_flush(dcache_flush), .halt(halt),
      .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   logic [40:0] exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          m_phase;       // 0 running, 1 draining, 2 flushing, 3 halted
   int unsigned m_cnt;

   // Monitor: outputs are combinational, so one response is due every cycle.
   always @(negedge CLK) begin
      logic [40:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pcen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
              dcache_flush, halt, stall_cnt};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL outputs t=%0t ctl got=%b exp=%b stall_cnt got=%0d exp=%0d",
                     $time, a[40:32], e[40:32], a[31:0], e[31:0]);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, want);
      end
   endtask

   task automatic idle_inputs();
      ihit = 1; dhit = 0; mem_dren = 0; mem_dwen = 0; ex_dren = 0;
      ex_rt = 0; id_rs = 0; id_rt = 0; ex_branch = 0; ex_beq = 0; ex_equal = 0;
      id_jump = 0; wb_halt = 0; flush_done = 0;
   endtask

   // Reference model: apply the pipeline rules to the current inputs, push the
   // expected outputs, advance the model, then move to the next cycle.
   task automatic step();
      bit adv, tk, luh;
      bit [8:0] ctl;   // pcen ifid_en ifid_f idex_en idex_f exmem memwb dflush halt
      int nxt;
      nxt = m_phase;
      ctl = '0;
      adv = ihit && (!(mem_dren || mem_dwen) || dhit);
      tk  = ex_branch && (ex_beq == ex_equal);
      luh = ex_dren && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
      case (m_phase)
         0: begin
            if (adv) begin
               if (tk)            ctl = 9'b111111100;
               else if (luh)      ctl = 9'b000111100;
               else if (id_jump)  ctl = 9'b111101100;
               else               ctl = 9'b110101100;
               if (wb_halt) nxt = 1;
            end
         end
         1: nxt = 2;
         2: begin
            ctl = 9'b000000010;
            if (flush_done) nxt = 3;
         end
         default: ctl = 9'b000000001;
      endcase
      exp_q.push_back({ctl, m_cnt});
      if (m_phase == 0 && !adv && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      m_phase = nxt;
      @(posedge CLK);
      #2;
   endtask

   // Async reset from any point; halt and dcache_flush must drop before any clock.
   task automatic do_reset();
      nRST = 0;
      #1;
      check("async_halt", {31'd0, halt}, 32'd0);
      check("async_dflush", {31'd0, dcache_flush}, 32'd0);
      check("async_cnt", stall_cnt, 32'd0);
      @(posedge CLK);
      #2;
      nRST = 1;
      m_phase = 0;
      m_cnt = 0;
   endtask

   task automatic rand_inputs(input int halt_odds);
      ihit       = ($urandom_range(0, 4) != 0);
      dhit       = $urandom_range(0, 1);
      mem_dren   = ($urandom_range(0, 3) == 0);
      mem_dwen   = ($urandom_range(0, 5) == 0);
      ex_dren    = $urandom_range(0, 1);
      ex_rt      = 5'($urandom_range(0, 3));
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_branch  = ($urandom_range(0, 2) == 0);
      ex_beq     = $urandom_range(0, 1);
      ex_equal   = $urandom_range(0, 1);
      id_jump    = ($urandom_range(0, 3) == 0);
      wb_halt    = ($urandom_range(0, halt_odds) == 0);
      flush_done = ($urandom_range(0, 2) == 0);
   endtask

   initial begin
      idle_inputs();
      m_phase = 0;
      m_cnt = 0;
      @(posedge CLK);
      #2;
      nRST = 1;

      // Plain run after reset.
      step();
      step();
      // Memory stall for three cycles, then resume.
      mem_dren = 1;
      repeat (3) step();
      dhit = 1;
      step();
      idle_inputs();
      step();
      // Load-use with a real register, then with $zero.
      ex_dren = 1; ex_rt = 8; id_rs = 8;
      step();
      ex_rt = 0; id_rs = 0;
      step();
      // Taken bne beats jump and load-use; then not taken falls to the jump.
      ex_dren = 1; ex_rt = 8; id_rs = 9; id_rt = 8;
      ex_branch = 1; ex_beq = 0; ex_equal = 0; id_jump = 1;
      step();
      ex_dren = 0; ex_equal = 1;
      step();
      idle_inputs();
      // Halt: drain, four flush cycles waiting, then done.
      wb_halt = 1;
      step();
      wb_halt = 0;
      step();
      repeat (4) step();
      flush_done = 1;
      step();
      flush_done = 0;
      for (int i = 0; i < 6; i++) begin
         ihit = i[0];
         step();
      end
      do_reset();
      // Reset while the flush is pending.
      wb_halt = 1;
      step();
      wb_halt = 0;
      step();
      step();
      do_reset();
      idle_inputs();
      step();

      // Random episodes, each closed by an async reset.
      for (int ep = 0; ep < 6; ep++) begin
         for (int c = 0; c < 150; c++) begin
            rand_inputs(ep[0] ? 25 : 60);
            step();
         end
         do_reset();
      end

      idle_inputs();
      step();
      @(negedge CLK);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
